sdram_device_responder: RTL and testbench



---
 rtl/sdram_pkg.sv | 36 +++
 rtl/sdram_device_responder_if.sv | 24 ++
 rtl/sdram_bank_fsm.sv | 75 +++++++
 rtl/sdram_device_responder.sv | 204 ++++++++++++++++++++
 tb/tb_sdram_device_responder.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM device responder: command encodings,
// mode register fields, bank state type and error flag positions.
package sdram_pkg;

  // {RAS_n, CAS_n, WE_n}
  localparam logic [2:0] CmdNop       = 3'b111;
  localparam logic [2:0] CmdActive    = 3'b011;
  localparam logic [2:0] CmdRead      = 3'b101;
  localparam logic [2:0] CmdWrite     = 3'b100;
  localparam logic [2:0] CmdBst       = 3'b110;
  localparam logic [2:0] CmdPrecharge = 3'b010;
  localparam logic [2:0] CmdRefresh   = 3'b001;
  localparam logic [2:0] CmdLoadMode  = 3'b000;

  // Mode register fields
  localparam int unsigned MrClLsb   = 4;
  localparam int unsigned MrClMsb   = 6;
  localparam int unsigned MrWbModeBit = 9;

  // MADDR[10]: auto-precharge on READ/WRITE, all-banks on PRECHARGE
  localparam int unsigned AddrA10 = 10;

  typedef enum logic [1:0] {BankIdle, BankActive, BankPrecharging} bank_state_e;

  localparam int unsigned ErrTiming    = 0;
  localparam int unsigned ErrBankState = 1;
  localparam int unsigned ErrNotIdle   = 2;
  localparam int unsigned ErrInit      = 3;
  localparam int unsigned ErrWatchdog  = 4;

  // Only CL2 and CL3 are supported; anything else behaves as CL2.
  function automatic logic [1:0] cas_latency(input logic [2:0] field);
    return (field == 3'd3) ? 2'd3 : 2'd2;
  endfunction

endpackage

// File: rtl/sdram_device_responder_if.sv
// SDRAM command/data bus between controller (master) and device (slave).
interface sdram_device_responder_if;
  logic        CKE;
  logic        CS_n;
  logic        RAS_n;
  logic        CAS_n;
  logic        WE_n;
  logic [1:0]  BA;
  logic [12:0] MADDR;
  logic [3:0]  DQM_n;
  logic [31:0] DQ_in;
  logic [31:0] DQ_out;
  logic [3:0]  DQ_oe;

  modport master (
    output CKE, CS_n, RAS_n, CAS_n, WE_n, BA, MADDR, DQM_n, DQ_in,
    input  DQ_out, DQ_oe
  );

  modport slave (
    input  CKE, CS_n, RAS_n, CAS_n, WE_n, BA, MADDR, DQM_n, DQ_in,
    output DQ_out, DQ_oe
  );
endinterface

// File: rtl/sdram_bank_fsm.sv
// One SDRAM bank: IDLE/ACTIVE/PRECHARGING state, open-row latch and the
// tRCD / tRP countdown timers. Timers run on every clock, even in suspend.
module sdram_bank_fsm
  import sdram_pkg::*;
#(
  parameter int unsigned ROW_BITS = 4,
  parameter int unsigned T_RCD    = 2,
  parameter int unsigned T_RP     = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_act,
  input  logic                i_pre,
  input  logic [ROW_BITS-1:0] i_row,
  output bank_state_e         o_state,
  output logic [ROW_BITS-1:0] o_row,
  output logic                o_rcd_ok,
  output logic                o_rp_ok
);

  localparam int unsigned TMax = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int unsigned CntW = (TMax > 1) ? $clog2(TMax) : 1;

  bank_state_e         r_state, w_state_d;
  logic [ROW_BITS-1:0] r_row, w_row_d;
  logic [CntW-1:0]     r_rcd, w_rcd_d;
  logic [CntW-1:0]     r_rp, w_rp_d;

  // Next state: a zero count means the constraint is met on this edge, so a
  // precharge completing and a new ACTIVE can share the same edge.
  always_comb begin
    w_state_d = r_state;
    w_row_d   = r_row;
    w_rcd_d   = (r_rcd != '0) ? r_rcd - 1'b1 : '0;
    w_rp_d    = (r_rp != '0) ? r_rp - 1'b1 : '0;
    case (r_state)
      BankActive: begin
        if (i_pre) begin
          w_state_d = BankPrecharging;
          w_rp_d    = CntW'(T_RP - 1);
        end
      end
      BankPrecharging: begin
        if (r_rp == '0) w_state_d = BankIdle;
      end
      default: ;
    endcase
    if (i_act) begin
      w_state_d = BankActive;
      w_row_d   = i_row;
      w_rcd_d   = CntW'(T_RCD - 1);
    end
  end

  // State and timer registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= BankIdle;
      r_row   <= '0;
      r_rcd   <= '0;
      r_rp    <= '0;
    end else begin
      r_state <= w_state_d;
      r_row   <= w_row_d;
      r_rcd   <= w_rcd_d;
      r_rp    <= w_rp_d;
    end
  end

  assign o_state  = r_state;
  assign o_row    = r_row;
  assign o_rcd_ok = (r_rcd == '0);
  assign o_rp_ok  = (r_rp == '0);

endmodule

// File: rtl/sdram_device_responder.sv
// SDRAM device responder: command decode, bank tracking, data array, CAS
// latency read pipeline with CKE suspend, refresh/mode state, sticky errors.
// Optional refresh watchdog: define SDRAM_REFRESH_WATCHDOG_EN.
module sdram_device_responder
  import sdram_pkg::*;
#(
  parameter int unsigned ROW_BITS  = 4,
  parameter int unsigned COL_BITS  = 4,
  parameter int unsigned T_RCD     = 2,
  parameter int unsigned T_RP      = 2,
  parameter int unsigned T_RFC     = 4,
  parameter int unsigned TREFI_MAX = 64
) (
  input  logic                       CLK,
  input  logic                       RESET,
  sdram_device_responder_if.slave    bus,
  output logic [12:0]                mode_reg,
  output logic                       init_done,
  output logic [4:0]                 err
);

  localparam int unsigned AddrW = 2 + ROW_BITS + COL_BITS;
  localparam int unsigned Depth = 1 << AddrW;
  localparam int unsigned RfcW  = (T_RFC > 1) ? $clog2(T_RFC) : 1;

  logic        r_cke_q;
  logic [12:0] r_mode;
  logic        r_init_done;
  logic [4:0]  r_err, w_err_d;
  logic [1:0]  r_ref_cnt;
  logic [RfcW-1:0] r_rfc;
  logic [31:0] r_dq_out;
  logic [3:0]  r_dq_oe;
  logic        r_pipe_vld  [3];
  logic [31:0] r_pipe_data [3];
  logic [3:0]  r_pipe_oe   [3];
  logic [31:0] r_mem [Depth];

  // Decode; nothing is accepted on a suspended edge
  logic [2:0] w_cmd;
  logic       w_vld, w_act, w_rd, w_wr, w_pre, w_ref, w_lmr, w_any;
  assign w_cmd = {bus.RAS_n, bus.CAS_n, bus.WE_n};
  assign w_vld = r_cke_q & ~bus.CS_n;
  assign w_act = w_vld && (w_cmd == CmdActive);
  assign w_rd  = w_vld && (w_cmd == CmdRead);
  assign w_wr  = w_vld && (w_cmd == CmdWrite);
  assign w_pre = w_vld && (w_cmd == CmdPrecharge);
  assign w_ref = w_vld && (w_cmd == CmdRefresh);
  assign w_lmr = w_vld && (w_cmd == CmdLoadMode);
  assign w_any = w_vld && (w_cmd != CmdNop);

  bank_state_e         w_bank_state [4];
  logic [ROW_BITS-1:0] w_bank_row   [4];
  logic [3:0]          w_rcd_ok, w_rp_ok, w_bank_act, w_bank_pre, w_idle, w_rp_pend;

  for (genvar b = 0; b < 4; b++) begin : g_bank
    logic w_hit;
    assign w_hit         = (bus.BA == 2'(b));
    assign w_bank_act[b] = w_act && w_hit;
    assign w_bank_pre[b] = (w_pre && (bus.MADDR[AddrA10] || w_hit)) ||
                           ((w_rd || w_wr) && bus.MADDR[AddrA10] && w_hit);
    // A bank whose tRP expires on this edge counts as idle
    assign w_idle[b]     = (w_bank_state[b] == BankIdle) ||
                           ((w_bank_state[b] == BankPrecharging) && w_rp_ok[b]);
    assign w_rp_pend[b]  = (w_bank_state[b] == BankPrecharging) && !w_rp_ok[b];

    sdram_bank_fsm #(
      .ROW_BITS (ROW_BITS),
      .T_RCD    (T_RCD),
      .T_RP     (T_RP)
    ) u_bank (
      .i_clk    (CLK),
      .i_rst    (RESET),
      .i_act    (w_bank_act[b]),
      .i_pre    (w_bank_pre[b]),
      .i_row    (bus.MADDR[ROW_BITS-1:0]),
      .o_state  (w_bank_state[b]),
      .o_row    (w_bank_row[b]),
      .o_rcd_ok (w_rcd_ok[b]),
      .o_rp_ok  (w_rp_ok[b])
    );
  end

  logic [AddrW-1:0] w_addr;
  logic [1:0]       w_cl;
  logic             w_wd_hit;
  assign w_addr = {bus.BA, w_bank_row[bus.BA], bus.MADDR[COL_BITS-1:0]};
  assign w_cl   = cas_latency(r_mode[MrClMsb:MrClLsb]);

  // Sticky protocol checks
  always_comb begin
    w_err_d = r_err;
    if (w_any && (r_rfc != '0)) w_err_d[ErrTiming] = 1'b1;
    if (w_act) begin
      if (w_rp_pend[bus.BA]) w_err_d[ErrTiming] = 1'b1;
      if (w_bank_state[bus.BA] == BankActive) w_err_d[ErrBankState] = 1'b1;
      if (!r_init_done) w_err_d[ErrInit] = 1'b1;
    end
    if (w_rd || w_wr) begin
      if (!w_rcd_ok[bus.BA]) w_err_d[ErrTiming] = 1'b1;
      if (w_bank_state[bus.BA] != BankActive) w_err_d[ErrBankState] = 1'b1;
      if (!r_init_done) w_err_d[ErrInit] = 1'b1;
    end
    if (w_ref) begin
      if (|w_rp_pend) w_err_d[ErrTiming] = 1'b1;
      if (!(&w_idle)) w_err_d[ErrNotIdle] = 1'b1;
    end
    if (w_lmr && !(&w_idle)) w_err_d[ErrNotIdle] = 1'b1;
    if (w_wd_hit) w_err_d[ErrWatchdog] = 1'b1;
  end

  // Control state: CKE copy, mode, refresh bookkeeping, errors.
  // CKE resets to "running" so the first edge after reset is not suspended.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cke_q     <= 1'b1;
      r_mode      <= '0;
      r_init_done <= 1'b0;
      r_err       <= '0;
      r_ref_cnt   <= '0;
      r_rfc       <= '0;
    end else begin
      r_cke_q <= bus.CKE;
      r_err   <= w_err_d;
      if (w_ref) begin
        r_rfc <= RfcW'(T_RFC - 1);
        if (r_ref_cnt != 2'd3) r_ref_cnt <= r_ref_cnt + 2'd1;
      end else if (r_rfc != '0) begin
        r_rfc <= r_rfc - 1'b1;
      end
      if (w_lmr) begin
        r_mode <= bus.MADDR;
        if (r_ref_cnt >= 2'd2) r_init_done <= 1'b1;
      end
    end
  end

  // Read pipeline: a READ enters stage CL-1 and reaches the pins CL active
  // edges later; everything freezes on suspended edges.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_dq_out <= '0;
      r_dq_oe  <= '0;
      for (int i = 0; i < 3; i++) begin
        r_pipe_vld[i]  <= 1'b0;
        r_pipe_data[i] <= '0;
        r_pipe_oe[i]   <= '0;
      end
    end else if (r_cke_q) begin
      r_dq_oe <= r_pipe_vld[0] ? r_pipe_oe[0] : 4'b0000;
      if (r_pipe_vld[0]) r_dq_out <= r_pipe_data[0];
      for (int i = 0; i < 2; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i+1];
        r_pipe_data[i] <= r_pipe_data[i+1];
        r_pipe_oe[i]   <= r_pipe_oe[i+1];
      end
      r_pipe_vld[2] <= 1'b0;
      if (w_rd) begin
        r_pipe_vld[w_cl - 2'd1]  <= 1'b1;
        r_pipe_data[w_cl - 2'd1] <= r_mem[w_addr];
        r_pipe_oe[w_cl - 2'd1]   <= ~bus.DQM_n;
      end
    end
  end

  // Storage: byte-masked write on the command edge; never cleared by reset
  always_ff @(posedge CLK) begin
    if (w_wr && !RESET) begin
      for (int i = 0; i < 4; i++) begin
        if (!bus.DQM_n[i]) r_mem[w_addr][8*i +: 8] <= bus.DQ_in[8*i +: 8];
      end
    end
  end

`ifdef SDRAM_REFRESH_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TREFI_MAX + 2);
  localparam logic [WdW-1:0] WdLimit = WdW'(TREFI_MAX + 1);
  logic [WdW-1:0] r_wd, w_wd_d;

  // Watchdog next value: cleared by REFRESH, idle until init, saturating
  always_comb begin
    w_wd_d = r_wd;
    if (w_ref) w_wd_d = '0;
    else if (r_init_done && (r_wd != WdLimit)) w_wd_d = r_wd + 1'b1;
  end

  // Watchdog counter register
  always_ff @(posedge CLK) begin
    if (RESET) r_wd <= '0;
    else       r_wd <= w_wd_d;
  end

  assign w_wd_hit = (w_wd_d == WdLimit);
`else
  assign w_wd_hit = 1'b0;
`endif

  assign bus.DQ_out = r_dq_out;
  assign bus.DQ_oe  = r_dq_oe;
  assign mode_reg   = r_mode;
  assign init_done  = r_init_done;
  assign err        = r_err;

endmodule

// File: tb/tb_sdram_device_responder.sv
// Directed bench for sdram_device_responder: init, CL2/CL3 reads, byte
// masks, CKE suspend, reset abort, protocol error flags and the watchdog.
module tb_sdram_device_responder;
  import sdram_pkg::*;

  logic        CLK;
  logic        RESET;
  logic [12:0] mode_reg;
  logic        init_done;
  logic [4:0]  err;
  int          n_assert;
  int          n_fail;

`ifdef SDRAM_REFRESH_WATCHDOG_EN
  localparam logic WdExp = 1'b1;
`else
  localparam logic WdExp = 1'b0;
`endif

  sdram_device_responder_if bus ();

  sdram_device_responder dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .bus       (bus),
    .mode_reg  (mode_reg),
    .init_done (init_done),
    .err       (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic issue(input logic [2:0] cmd, input logic [1:0] ba, input logic [12:0] addr,
                       input logic [3:0] dqm, input logic [31:0] data);
    bus.CS_n = 1'b0;
    {bus.RAS_n, bus.CAS_n, bus.WE_n} = cmd;
    bus.BA = ba;
    bus.MADDR = addr;
    bus.DQM_n = dqm;
    bus.DQ_in = data;
    step();
    bus.CS_n = 1'b1;
    {bus.RAS_n, bus.CAS_n, bus.WE_n} = CmdNop;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    nop(2);
    RESET = 1'b0;
  endtask

  task automatic init_seq(input logic [12:0] mode);
    issue(CmdRefresh, 2'd0, 13'h0, 4'hF, 32'h0);
    nop(3);
    issue(CmdRefresh, 2'd0, 13'h0, 4'hF, 32'h0);
    nop(3);
    issue(CmdLoadMode, 2'd0, mode, 4'hF, 32'h0);
    check("init_done", 32'(init_done), 32'h1);
    check("mode_reg", 32'(mode_reg), 32'(mode));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    RESET = 1'b1;
    bus.CKE = 1'b1;
    bus.CS_n = 1'b1;
    {bus.RAS_n, bus.CAS_n, bus.WE_n} = CmdNop;
    bus.BA = '0;
    bus.MADDR = '0;
    bus.DQM_n = 4'hF;
    bus.DQ_in = '0;
    nop(2);
    RESET = 1'b0;

    check("rst_dq_oe", 32'(bus.DQ_oe), 32'h0);
    check("rst_dq_out", bus.DQ_out, 32'h0);
    check("rst_mode", 32'(mode_reg), 32'h0);
    check("rst_init", 32'(init_done), 32'h0);
    check("rst_err", 32'(err), 32'h0);

    init_seq(13'h220);
    check("init_err", 32'(err), 32'h0);

    // Watchdog: init_done is 60 and then 70 cycles old with no refresh
    nop(60);
    check("wd_quiet", 32'(err[4]), 32'h0);
    nop(10);
    check("wd_fired", 32'(err[4]), 32'(WdExp));

    // CL2 write with auto-precharge, reopen after tRP, read back
    issue(CmdActive, 2'd1, 13'd5, 4'hF, 32'h0);
    nop(1);
    issue(CmdWrite, 2'd1, 13'h403, 4'h0, 32'hDEADBEEF);
    nop(1);
    issue(CmdActive, 2'd1, 13'd5, 4'hF, 32'h0);
    nop(1);
    issue(CmdRead, 2'd1, 13'h003, 4'h0, 32'h0);
    check("cl2_early_oe", 32'(bus.DQ_oe), 32'h0);
    nop(1);
    check("cl2_early_oe2", 32'(bus.DQ_oe), 32'h0);
    nop(1);
    check("cl2_data", bus.DQ_out, 32'hDEADBEEF);
    check("cl2_oe", 32'(bus.DQ_oe), 32'hF);
    nop(1);
    check("cl2_oe_drop", 32'(bus.DQ_oe), 32'h0);
    check("cl2_err", 32'(err[3:0]), 32'h0);

    // Byte-masked write over DEADBEEF, then reads with and without masks
    issue(CmdWrite, 2'd1, 13'h003, 4'b0101, 32'h11223344);
    issue(CmdRead, 2'd1, 13'h003, 4'h0, 32'h0);
    nop(2);
    check("mask_data", bus.DQ_out, 32'h11AD33EF);
    issue(CmdRead, 2'd1, 13'h003, 4'b0011, 32'h0);
    nop(2);
    check("mask_oe", 32'(bus.DQ_oe), 32'hC);
    check("mask_err", 32'(err[3:0]), 32'h0);

    // Precharge all, switch to CL3
    issue(CmdPrecharge, 2'd0, 13'h400, 4'hF, 32'h0);
    nop(2);
    issue(CmdLoadMode, 2'd0, 13'h230, 4'hF, 32'h0);
    check("cl3_mode", 32'(mode_reg), 32'h230);
    issue(CmdActive, 2'd1, 13'd5, 4'hF, 32'h0);
    nop(1);

    // CL3 read with CKE low for 5 cycles starting one edge after READ
    issue(CmdRead, 2'd1, 13'h003, 4'h0, 32'h0);
    bus.CKE = 1'b0;
    nop(5);
    check("susp_oe", 32'(bus.DQ_oe), 32'h0);
    bus.CKE = 1'b1;
    nop(1);
    check("susp_oe_e6", 32'(bus.DQ_oe), 32'h0);
    nop(1);
    check("susp_oe_e7", 32'(bus.DQ_oe), 32'h0);
    nop(1);
    check("susp_data_e8", bus.DQ_out, 32'h11AD33EF);
    check("susp_oe_e8", 32'(bus.DQ_oe), 32'hF);
    nop(1);
    check("susp_oe_e9", 32'(bus.DQ_oe), 32'h0);

    // Output frozen while suspended during its valid window
    issue(CmdRead, 2'd1, 13'h003, 4'h0, 32'h0);
    nop(2);
    bus.CKE = 1'b0;
    nop(1);
    check("frz_oe_f3", 32'(bus.DQ_oe), 32'hF);
    nop(1);
    check("frz_oe_f4", 32'(bus.DQ_oe), 32'hF);
    bus.CKE = 1'b1;
    nop(1);
    check("frz_oe_f5", 32'(bus.DQ_oe), 32'hF);
    check("frz_data_f5", bus.DQ_out, 32'h11AD33EF);
    nop(1);
    check("frz_oe_f6", 32'(bus.DQ_oe), 32'h0);
    check("frz_err", 32'(err[3:0]), 32'h0);

    // Reset one edge before CL3 data is due
    issue(CmdRead, 2'd1, 13'h003, 4'h0, 32'h0);
    nop(2);
    RESET = 1'b1;
    nop(1);
    check("abort_oe", 32'(bus.DQ_oe), 32'h0);
    nop(1);
    RESET = 1'b0;
    check("abort_out", bus.DQ_out, 32'h0);
    check("abort_mode", 32'(mode_reg), 32'h0);
    check("abort_init", 32'(init_done), 32'h0);
    check("abort_err", 32'(err), 32'h0);

    // ACTIVE before init
    issue(CmdActive, 2'd0, 13'd0, 4'hF, 32'h0);
    check("err_init", 32'(err), 32'h08);
    do_reset();

    // Array survives reset
    init_seq(13'h220);
    issue(CmdActive, 2'd1, 13'd5, 4'hF, 32'h0);
    nop(1);
    issue(CmdRead, 2'd1, 13'h003, 4'h0, 32'h0);
    nop(2);
    check("keep_data", bus.DQ_out, 32'h11AD33EF);
    check("keep_err", 32'(err), 32'h0);
    do_reset();

    // tRCD violation
    init_seq(13'h220);
    issue(CmdActive, 2'd0, 13'd0, 4'hF, 32'h0);
    issue(CmdRead, 2'd0, 13'd0, 4'h0, 32'h0);
    check("err_trcd", 32'(err), 32'h01);
    do_reset();

    // ACTIVE to an open bank
    init_seq(13'h220);
    issue(CmdActive, 2'd2, 13'd1, 4'hF, 32'h0);
    nop(3);
    issue(CmdActive, 2'd2, 13'd2, 4'hF, 32'h0);
    check("err_bank", 32'(err), 32'h02);
    do_reset();

    // REFRESH with a bank open
    init_seq(13'h220);
    issue(CmdActive, 2'd3, 13'd1, 4'hF, 32'h0);
    nop(3);
    issue(CmdRefresh, 2'd0, 13'h0, 4'hF, 32'h0);
    check("err_ref_open", 32'(err), 32'h04);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
